// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state type and scaling constant for the PWM capture block
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_ARM,
        ST_MEASURE,
        ST_TIMEOUT
    } pwm_state_t;

    localparam int PCT_SCALE = 100;

endpackage

// File: rtl/pwm_div.sv
// rtl/pwm_div.sv - unsigned restoring divider, one quotient bit per cycle
module pwm_div #(
    parameter int NUM_W = 23,
    parameter int DEN_W = 16,
    parameter int QUO_W = NUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [QUO_W-1:0] quot
);

    localparam int CW = $clog2(NUM_W + 1);

    logic [DEN_W-1:0] rem_q;
    logic [DEN_W-1:0] den_q;
    logic [NUM_W-1:0] quo_q;
    logic [CW-1:0]    cnt_q;

    logic [DEN_W:0]   shifted;
    logic [DEN_W:0]   trial;
    logic             q_bit;
    logic [DEN_W-1:0] rem_nxt;
    logic [NUM_W-1:0] quo_nxt;

    // The partial remainder stays below den, so DEN_W+1 bits hold the shifted value.
    assign shifted = {rem_q, quo_q[NUM_W-1]};
    assign trial   = shifted - {1'b0, den_q};
    assign q_bit   = ~trial[DEN_W];
    assign rem_nxt = q_bit ? trial[DEN_W-1:0] : shifted[DEN_W-1:0];
    assign quo_nxt = {quo_q[NUM_W-2:0], q_bit};

    // done is raised during the final iteration so the caller can register the result with it.
    assign done = busy && (cnt_q == CW'(1));
    assign quot = quo_nxt[QUO_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            rem_q <= '0;
            den_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (start && !busy) begin
            busy  <= 1'b1;
            rem_q <= '0;
            den_q <= den;
            quo_q <= num;
            cnt_q <= CW'(NUM_W);
        end else if (busy) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures period, high time and duty cycle of an asynchronous PWM input
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [6:0]       duty_pct,
    output logic             valid,
    output logic             timeout,
    output logic             overrun
);

    localparam int               NUM_W   = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   lvl_d;
    logic                   rise;

    pwm_state_t state_q, state_d;
    logic [CNT_W-1:0] per_q, hi_q;
    logic [CNT_W-1:0] pend_per, pend_hi;
    logic             div_start, drop, sat;

    logic [NUM_W-1:0] div_num;
    logic             div_busy, div_done;
    logic [6:0]       div_quot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            lvl_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            lvl_d  <= lvl;
        end
    end

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = lvl & ~lvl_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        drop      = 1'b0;
        sat       = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (rise) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (rise) begin
                    if (div_busy) drop = 1'b1;
                    else          div_start = 1'b1;
                end else if (per_q == CNT_MAX) begin
                    sat     = 1'b1;
                    state_d = ST_TIMEOUT;
                end
            end
            ST_TIMEOUT: begin
                if (rise) state_d = ST_MEASURE;
            end
            default: state_d = ST_ARM;
        endcase
    end

    // High time counts the edge-detect flop, so the rise cycle itself lands in the new period's
    // high count one cycle late, and the cycle before the next rise is always low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q    <= '0;
            hi_q     <= '0;
            pend_per <= '0;
            pend_hi  <= '0;
        end else begin
            if (rise) begin
                per_q <= CNT_W'(1);
                hi_q  <= '0;
            end else if (state_d == ST_MEASURE) begin
                per_q <= per_q + CNT_W'(1);
                hi_q  <= hi_q + {{(CNT_W-1){1'b0}}, lvl_d};
            end else begin
                per_q <= '0;
                hi_q  <= '0;
            end
            if (div_start) begin
                pend_per <= per_q;
                pend_hi  <= hi_q;
            end
        end
    end

    assign div_num = NUM_W'(hi_q) * NUM_W'(PCT_SCALE);

    pwm_div #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W),
        .QUO_W (7)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .num   (div_num),
        .den   (per_q),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            duty_pct   <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            valid   <= 1'b0;
            overrun <= drop;
            timeout <= (state_d == ST_TIMEOUT);
            if (div_done) begin
                valid      <= 1'b1;
                period_cnt <= pend_per;
                high_cnt   <= pend_hi;
                duty_pct   <= div_quot;
            end else if (sat) begin
                valid      <= 1'b1;
                period_cnt <= '0;
                high_cnt   <= '0;
                duty_pct   <= lvl ? 7'(PCT_SCALE) : 7'd0;
            end
        end
    end

endmodule
